uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//   Receives 8N1 UART frames on a serial line and delivers each byte as a parallel word.
//   Sits directly downstream of the SoC UART transmitter (tx_serial). It closes the loopback
//   path used in SoC tests and becomes the receive half of the memory-mapped UART peripheral.
//   Has a one-entry holding register with a valid/ready handshake, plus framing-error and
//   overrun reporting.
// PARAMETERS
//   CLKS_PER_BIT  10  clk cycles per serial bit (100 ns/bit at 10 ns clk); legal range >= 4
//   SYNC_STAGES   2   flops in the rx input synchronizer; legal range >= 2
// PORTS
//   clk        in   1  system clock, all logic on rising edge
//   rst        in   1  synchronous, active-high reset
//   rx_serial  in   1  asynchronous serial input, idle high
//   rx_data    out  8  received byte, stable while rx_valid=1
//   rx_valid   out  1  holding register full
//   rx_ready   in   1  consumer accepts byte when rx_valid&rx_ready
//   frame_err  out  1  1-cycle pulse: stop bit sampled low
//   overrun    out  1  1-cycle pulse: byte completed while holding register full
//   busy       out  1  high in any state other than IDLE
// BEHAVIOUR
//   Reset (rst=1 at a clk edge): state=IDLE; rx_data=8'h00; rx_valid, frame_err, overrun,
//     busy all 0; synchronizer flops=1; counters=0. Reset mid-frame aborts the frame and
//     produces no output.
//   Synchronizer: rx_serial passes through SYNC_STAGES flops to give rx_s. All FSM decisions
//     use rx_s only.
//   Counters: bit_cnt counts 0..CLKS_PER_BIT-1; bit_idx counts 0..7. HALF=(CLKS_PER_BIT-1)/2.
//   FSM:
//     IDLE  : if rx_s==0, go to START with bit_cnt=0.
//     START : bit_cnt increments. At bit_cnt==HALF: if rx_s==0, go to DATA with bit_cnt=0 and
//             bit_idx=0; else (glitch) go to IDLE with no output.
//     DATA  : at bit_cnt==CLKS_PER_BIT-1, sample rx_s into shift[bit_idx] (LSB first) and
//             clear bit_cnt. After bit_idx==7 is sampled, go to STOP; else bit_idx+1.
//     STOP  : at bit_cnt==CLKS_PER_BIT-1, sample rx_s.
//               rx_s==1 -> deliver byte (see below), go to IDLE.
//               rx_s==0 -> pulse frame_err, discard byte, go to BREAK.
//     BREAK : wait until rx_s==1, then go to IDLE. A held-low line yields exactly one frame_err.
//   Sampling: each data/stop sample falls at the bit midpoint, +/-1 clk.
//   Delivery (the cycle after the good stop sample):
//     rx_valid==0                 -> rx_data<=shift, rx_valid<=1.
//     rx_valid==1 and rx_ready==1 -> the old byte is consumed and the new byte loaded in the
//                                    same cycle; rx_valid stays 1; no overrun.
//     rx_valid==1 and rx_ready==0 -> the new byte is dropped, the old byte is kept, and overrun
//                                    pulses for 1 cycle.
//   Handshake: rx_valid&rx_ready with no delivery that cycle -> rx_valid<=0 next cycle.
//     rx_data holds its value after consumption. rx_ready while rx_valid=0 is ignored.
//   Latency: rx_valid rises 1 cycle after the stop sample, about
//     SYNC_STAGES + HALF + 9*CLKS_PER_BIT + 1 cycles after the falling edge at the pin.
//   Back-to-back frames: IDLE is re-entered mid stop bit, so a start edge immediately
//     after the stop bit is detected.
//   frame_err and overrun never assert in the same cycle. busy=0 only in IDLE.
// TESTING
//   1. 'H' 8'h48 at 10 clk/bit, rx_ready=1 -> rx_valid 1 cycle, rx_data=8'h48, no error pulses.
//   2. 'H' then 'I' back-to-back (no idle gap), rx_ready=1 -> 8'h48 then 8'h49 in order.
//   3. rx_serial low for 3 clks then high -> no rx_valid; busy returns to 0 within 7 clks.
//   4. Frame 8'hA5 with stop bit 0, then line high -> one frame_err pulse, rx_valid stays 0,
//      next frame 8'h3C received correctly.
//   5. rx_ready=0; send 8'h11 then 8'h22 -> rx_data=8'h11 kept, one overrun pulse; raise
//      rx_ready -> rx_valid drops next cycle.
//   6. rst=1 during bit 4 of 8'hFF -> all outputs reset; next frame 8'h5A delivered intact.
//      Also run SoC loopback: tx_serial->rx_serial yields 8'h48, 8'h49.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver: input synchronizer, mid-bit sampling FSM and a one-entry
// holding register with valid/ready handshake, framing-error and overrun pulses.
module uart_rx_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 10,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_serial,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  localparam int unsigned  CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rx_s;
  logic [CW-1:0]          r_bit_cnt, w_bit_cnt_nxt;
  logic [2:0]             r_bit_idx, w_bit_idx_nxt;
  logic [7:0]             r_shift, w_shift_nxt;
  logic                   w_stop_good;
  logic                   w_stop_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rx_serial};
    end
  end

  assign w_rx_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_stop_good   = 1'b0;
    w_stop_bad    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt   = S_START;
          w_bit_cnt_nxt = '0;
        end
      end
      S_START: begin
        // Start bit re-checked at its midpoint; a short low pulse is a glitch.
        if (r_bit_cnt == HALF) begin
          w_bit_cnt_nxt = '0;
          w_bit_idx_nxt = '0;
          w_state_nxt   = w_rx_s ? S_IDLE : S_DATA;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (r_bit_cnt == LAST) begin
          w_bit_cnt_nxt          = '0;
          w_shift_nxt[r_bit_idx] = w_rx_s;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (r_bit_cnt == LAST) begin
          w_bit_cnt_nxt = '0;
          if (w_rx_s) begin
            w_stop_good = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_stop_bad  = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        end
      end
      S_BREAK: begin
        if (w_rx_s) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // A consume and a new delivery in the same cycle reload instead of clearing valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= w_stop_bad;
      overrun   <= 1'b0;
      if (w_stop_good) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= r_shift;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: frames scheduled as timed events feed a
// holding-register model compared every cycle, plus literal pins per scenario.
module tb_uart_rx_ctrl;
  localparam int CPB  = 10;
  localparam int SYNC = 2;
  // Driven just after edge N, the start bit is seen at edge N+1; the byte is
  // visible SYNC + HALF + 9*CPB + 1 cycles after that.
  localparam int LAT  = 1 + SYNC + (CPB - 1) / 2 + 9 * CPB + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_serial;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_serial (rx_serial),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // model state: 0..255 = good byte, 256 = framing error, keyed by cycle
  int         ev[int];
  logic       mv = 1'b0;
  logic [7:0] md = 8'h00;
  logic       fe = 1'b0;
  logic       ov = 1'b0;
  logic       rdy_prev = 1'b0;
  logic       rst_prev = 1'b1;

  bit         valid_at[int];
  bit         busy_at[int];
  int         rise_cyc[$];
  logic [7:0] rise_data[$];
  int         ferr_cyc[$];
  int         ov_cyc[$];
  logic       prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 50)
        $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    int e;
    @(negedge clk);
    if (rst_prev) begin
      mv = 1'b0; md = 8'h00; fe = 1'b0; ov = 1'b0;
      ev.delete();
    end else begin
      fe = 1'b0; ov = 1'b0;
      e  = -1;
      if (ev.exists(cyc)) begin
        e = ev[cyc];
        ev.delete(cyc);
      end
      if (e >= 0 && e < 256) begin
        if (!mv || rdy_prev) begin
          mv = 1'b1;
          md = e[7:0];
        end else begin
          ov = 1'b1;
        end
      end else begin
        if (mv && rdy_prev) mv = 1'b0;
        if (e == 256) fe = 1'b1;
      end
    end
    check("valid", {31'd0, rx_valid}, {31'd0, mv});
    check("data", {24'd0, rx_data}, {24'd0, md});
    check("ferr", {31'd0, frame_err}, {31'd0, fe});
    check("ovr", {31'd0, overrun}, {31'd0, ov});
    valid_at[cyc] = rx_valid;
    busy_at[cyc]  = busy;
    if (rx_valid && !prev_valid) begin
      rise_cyc.push_back(cyc);
      rise_data.push_back(rx_data);
    end
    if (frame_err) ferr_cyc.push_back(cyc);
    if (overrun)   ov_cyc.push_back(cyc);
    prev_valid = rx_valid;
    rdy_prev   = rx_ready;
    rst_prev   = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] bits;
    ev[cyc + LAT] = stop ? int'(d) : 256;
    bits = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_serial = bits[i];
      repeat (CPB) tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, m, nr, nf, no;
    rst = 1'b1; rx_serial = 1'b1; rx_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_data", {24'd0, rx_data}, 32'h00);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    repeat (5) tick();

    // 1: single 'H'
    rx_ready = 1'b1;
    n = cyc; nr = rise_cyc.size(); nf = ferr_cyc.size(); no = ov_cyc.size();
    send_frame(8'h48, 1'b1);
    repeat (5) tick();
    check("t1_rises", rise_cyc.size() - nr, 1);
    check("t1_latency", rise_cyc[nr], n + 98);
    check("t1_data", {24'd0, rise_data[nr]}, 32'h48);
    check("t1_one_cycle", {31'd0, valid_at[n + 99]}, 32'd0);
    check("t1_no_err", ferr_cyc.size() - nf + ov_cyc.size() - no, 0);

    // 2: 'H','I' back to back
    n = cyc; nr = rise_cyc.size();
    send_frame(8'h48, 1'b1);
    send_frame(8'h49, 1'b1);
    repeat (5) tick();
    check("t2_rises", rise_cyc.size() - nr, 2);
    check("t2_cyc0", rise_cyc[nr], n + 98);
    check("t2_data0", {24'd0, rise_data[nr]}, 32'h48);
    check("t2_cyc1", rise_cyc[nr + 1], n + 198);
    check("t2_data1", {24'd0, rise_data[nr + 1]}, 32'h49);

    // 3: 3-clk glitch
    n = cyc; nr = rise_cyc.size();
    rx_serial = 1'b0;
    repeat (3) tick();
    rx_serial = 1'b1;
    repeat (12) tick();
    check("t3_busy_hi", {31'd0, busy_at[n + 3]}, 32'd1);
    check("t3_busy_lo", {31'd0, busy_at[n + 10]}, 32'd0);
    check("t3_no_valid", rise_cyc.size() - nr, 0);

    // 4: bad stop bit, then good frame
    n = cyc; nr = rise_cyc.size(); nf = ferr_cyc.size();
    send_frame(8'hA5, 1'b0);
    rx_serial = 1'b1;
    repeat (20) tick();
    check("t4_ferr_n", ferr_cyc.size() - nf, 1);
    check("t4_ferr_cyc", ferr_cyc[nf], n + 98);
    check("t4_no_valid", rise_cyc.size() - nr, 0);
    check("t4_idle", {31'd0, busy}, 32'd0);
    n = cyc;
    send_frame(8'h3C, 1'b1);
    repeat (5) tick();
    check("t4_next_cyc", rise_cyc[nr], n + 98);
    check("t4_next_data", {24'd0, rise_data[nr]}, 32'h3C);

    // 5: overrun with consumer stalled
    rx_ready = 1'b0;
    n = cyc; nr = rise_cyc.size(); no = ov_cyc.size();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (5) tick();
    check("t5_rises", rise_cyc.size() - nr, 1);
    check("t5_data_first", {24'd0, rise_data[nr]}, 32'h11);
    check("t5_ovr_n", ov_cyc.size() - no, 1);
    check("t5_ovr_cyc", ov_cyc[no], n + 198);
    check("t5_kept", {24'd0, rx_data}, 32'h11);
    m = cyc;
    rx_ready = 1'b1;
    repeat (3) tick();
    check("t5_hold", {31'd0, valid_at[m]}, 32'd1);
    check("t5_drop", {31'd0, valid_at[m + 1]}, 32'd0);
    check("t5_data_after", {24'd0, rx_data}, 32'h11);

    // 7: consume and reload in the delivery cycle
    rx_ready = 1'b0;
    send_frame(8'h77, 1'b1);
    repeat (5) tick();
    n = cyc; nr = rise_cyc.size(); no = ov_cyc.size();
    fork
      send_frame(8'h88, 1'b1);
      begin
        wait (cyc == n + 97);
        #1 rx_ready = 1'b1;
      end
    join
    repeat (5) tick();
    check("t7_stay", {31'd0, valid_at[n + 98]}, 32'd1);
    check("t7_drop", {31'd0, valid_at[n + 99]}, 32'd0);
    check("t7_data", {24'd0, rx_data}, 32'h88);
    check("t7_no_ovr", ov_cyc.size() - no, 0);
    check("t7_no_rise", rise_cyc.size() - nr, 0);

    // 6: reset during bit 4 of 8'hFF
    rx_ready = 1'b0;
    send_frame(8'h66, 1'b1);
    repeat (5) tick();
    check("t6_pre_valid", {31'd0, rx_valid}, 32'd1);
    rx_serial = 1'b0;
    repeat (CPB) tick();
    rx_serial = 1'b1;
    repeat (45) tick();
    check("t6_pre_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("t6_valid", {31'd0, rx_valid}, 32'd0);
    check("t6_data", {24'd0, rx_data}, 32'h00);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_ferr", {31'd0, frame_err}, 32'd0);
    check("t6_ovr", {31'd0, overrun}, 32'd0);
    repeat (5) tick();
    rx_ready = 1'b1;
    n = cyc; nr = rise_cyc.size();
    send_frame(8'h5A, 1'b1);
    repeat (5) tick();
    check("t6_next_cyc", rise_cyc[nr], n + 98);
    check("t6_next_data", {24'd0, rise_data[nr]}, 32'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
